missile_slot_arbiter: RTL and testbench
=======================================

Name: missile_slot_arbiter

Overview:
- Shares a fixed pool of missile sprite slots between the four shooters: player, monsters, boss and asteroids.
- Grants at most one fire request per cycle, using round-robin priority and a per-requester cooldown.
- Tracks slot occupancy and frees a slot when its missile leaves the screen or hits.
- Sits beside the game controller. The controller's per-object enables and resets drive req_enable and clear. The pause enable drives enable.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the player.
- NUM_SLOTS, 8, missile slots in the pool.
- RESERVED_SLOTS, 2, slots 0..RESERVED_SLOTS-1 are usable only by requester 0.
- COOLDOWN_CYCLES, 16, minimum number of enabled cycles between grants to the same requester.

Ports:
- clk, in, 1, system clock. One clock (clk); reset is synchronous and active-high (reset).
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, 0 = paused: no grants and cooldowns frozen.
- clear, in, 1, synchronous stage-restart pulse: empties the pool.
- fire_req, in, NUM_REQ, level request per requester.
- req_enable, in, NUM_REQ, requester allowed to fire; a masked request is ignored.
- slot_free, in, NUM_SLOTS, one-cycle pulse: the missile in that slot is gone.
- grant, out, NUM_REQ, one-hot, one-cycle pulse.
- grant_slot, out, $clog2(NUM_SLOTS), index of the slot granted; valid when grant is non-zero.
- launch, out, NUM_SLOTS, one-hot, one-cycle pulse that starts the missile in that slot.
- slot_busy, out, NUM_SLOTS, occupancy map.
- busy_count, out, $clog2(NUM_SLOTS+1), population count of slot_busy.

Behaviour:
- Reset (sync, active-high) values:
  - grant=0, launch=0, grant_slot=0, slot_busy=0, busy_count=0.
  - All cooldown counters 0; round-robin pointer rr_ptr=0.
- clear has the same effect as reset on all state. It has priority over slot_free and fire_req in the same cycle.
- Eligible requester i: fire_req[i] & req_enable[i] & (cooldown[i]==0) & enable, and a usable slot exists.
  - Usable slots for requester 0: any non-busy slot.
  - Usable slots for i>0: non-busy slots with index >= RESERVED_SLOTS.
- Selection, combinational, evaluated on the registered slot_busy:
  - Winner = first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Slot = lowest-index usable slot for the winner.
- Latency and registered outputs:
  - The request is sampled at edge N. grant, grant_slot and launch are asserted in cycle N+1 for exactly one cycle.
  - slot_busy[slot] is set from cycle N+1.
  - rr_ptr <= winner+1 (mod NUM_REQ).
  - cooldown[winner] <= COOLDOWN_CYCLES.
- Cooldown:
  - Each non-zero counter decrements by 1 per cycle while enable=1 and holds while enable=0.
  - A requester holding fire_req high is therefore re-granted every COOLDOWN_CYCLES+1 cycles at most.
- Freeing:
  - slot_free[k] with slot_busy[k]=1 clears the bit at the next edge.
  - slot_free on a non-busy slot is ignored.
  - Frees are processed while enable=0, so missiles exiting during pause are honoured.
- Simultaneous events:
  - A slot freed at edge N is not allocatable until selection in cycle N+1; allocation never uses the same-cycle free.
  - A free of slot a and an allocation of slot b in the same cycle are both applied.
  - If slot_free arrives for a slot in the same cycle it is being allocated (illegal: the slot was not busy), the allocation wins.
- Pool full for a requester: no grant. Its request stays pending and does not advance rr_ptr.
- req_enable dropping mid-cooldown: the counter keeps running. A disabled requester never wins.
- busy_count is registered and updated in the same cycle as slot_busy.

Decomposition:
- Package missile_pkg holds:
  - REQ_PLAYER=0, REQ_MONST=1, REQ_BOSS=2, REQ_ASTERO=3.
  - Default NUM_REQ, NUM_SLOTS and RESERVED_SLOTS.
  - Derived widths: REQ_W and SLOT_W.
- One natural sub-module, rr_priority_picker: combinational round-robin first-set finder.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner and winner index.
  - Reused for the lowest-free-slot search by tying the pointer to 0.

Test Plan:
1. After reset, hold fire_req=4'b0001 with req_enable=all 1, enable=1 → grant=0001, grant_slot=0, launch=8'h01 one cycle later. Re-grant occurs 17 cycles after the first grant; second slot_busy=8'h03.
2. Raise fire_req=4'b1110 in the same cycle from idle → grants go to requesters 1, 2, 3 on consecutive cycles, in slots 2, 3, 4. Requesters 1–3 never get slot 0 or 1.
3. Fill slots 2..7 with non-player grants, then request from requester 2 → no grant, busy_count=6. Pulse slot_free[5] → requester 2 granted slot 5 two cycles later.
4. Drop enable for 10 cycles mid-cooldown, pulsing slot_free[0] during the pause → no grants, cooldown value held, slot_busy[0] cleared. Cooldown resumes counting after enable=1.
5. Pulse clear with slot_busy=8'hFF and active cooldowns → the next cycle shows slot_busy=0, busy_count=0, rr_ptr=0. A player request is granted slot 0 immediately, with no cooldown wait.
6. fire_req=4'b0100 with req_enable=4'b1011 → no grant ever. Setting req_enable[2]=1 → grant=0100 one cycle later.

Source files
------------

// File: rtl/missile_pkg.sv
// missile_pkg: shared constants for the missile slot arbiter.
//   - Requester indices (player, monsters, boss, asteroids).
//   - Default pool geometry and cooldown length.
//   - Derived index and counter widths for the default geometry.
package missile_pkg;

  // Requester indices. Index 0 (the player) is the only requester that
  // may use the reserved low slots.
  localparam int REQ_PLAYER = 0;
  localparam int REQ_MONST  = 1;
  localparam int REQ_BOSS   = 2;
  localparam int REQ_ASTERO = 3;

  // Default geometry.
  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_NUM_SLOTS       = 8;
  localparam int DEF_RESERVED_SLOTS  = 2;
  localparam int DEF_COOLDOWN_CYCLES = 16;

  // Derived widths for the default geometry.
  localparam int REQ_W  = $clog2(DEF_NUM_REQ);
  localparam int SLOT_W = $clog2(DEF_NUM_SLOTS);
  localparam int CNT_W  = $clog2(DEF_NUM_SLOTS + 1);

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin first-set finder.
//   Scans req starting at index ptr, then ptr+1, ... modulo N, and reports
//   the first set bit.
// Ports:
//   req        in  [N-1:0]      candidate vector
//   ptr        in  [IDX_W-1:0]  index with highest priority this cycle
//   winner_oh  out [N-1:0]      one-hot winner (zero when nothing is set)
//   winner_idx out [IDX_W-1:0]  winner index (zero when nothing is set)
//   found      out              any bit of req set
// With ptr tied to zero this is a plain lowest-set-bit finder.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             found
);

  // The outer loop walks priority positions, the inner loop finds the
  // physical index for that position. Keeping every bit select indexed by
  // a loop constant keeps the generated mux tree static.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
          found        = 1'b1;
          winner_oh[i] = 1'b1;
          winner_idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/missile_slot_arbiter.sv
// missile_slot_arbiter: shares a pool of missile sprite slots between the
// shooters (player, monsters, boss, asteroids).
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   enable      in   0 = paused: no grants, cooldowns frozen (frees still taken)
//   clear       in   stage restart: same effect as reset
//   fire_req    in   [NUM_REQ-1:0]  level fire request per requester
//   req_enable  in   [NUM_REQ-1:0]  requester allowed to fire
//   slot_free   in   [NUM_SLOTS-1:0] pulse: missile in that slot is gone
//   grant       out  [NUM_REQ-1:0]  one-hot grant pulse
//   grant_slot  out  slot index of the grant (valid with grant)
//   launch      out  [NUM_SLOTS-1:0] one-hot launch pulse for the slot
//   slot_busy   out  [NUM_SLOTS-1:0] occupancy map
//   busy_count  out  population count of slot_busy
//
// Grant protocol: fire_req is a level request with no ready back-pressure.
// A request that is eligible when sampled at edge N is answered by a single
// cycle of grant/grant_slot/launch in cycle N+1; the requester learns of its
// grant only through that pulse and may keep fire_req high, in which case
// the cooldown spaces further grants COOLDOWN_CYCLES+1 cycles apart.
module missile_slot_arbiter
  import missile_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
  parameter int RESERVED_SLOTS  = DEF_RESERVED_SLOTS,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [NUM_REQ-1:0]             fire_req,
  input  logic [NUM_REQ-1:0]             req_enable,
  input  logic [NUM_SLOTS-1:0]           slot_free,
  output logic [NUM_REQ-1:0]             grant,
  output logic [$clog2(NUM_SLOTS)-1:0]   grant_slot,
  output logic [NUM_SLOTS-1:0]           launch,
  output logic [NUM_SLOTS-1:0]           slot_busy,
  output logic [$clog2(NUM_SLOTS+1)-1:0] busy_count
);

  localparam int RW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW  = $clog2(NUM_SLOTS);
  localparam int CW  = $clog2(NUM_SLOTS + 1);
  localparam int CDW = $clog2(COOLDOWN_CYCLES + 1);

  // State
  logic [NUM_REQ-1:0]   grant_q,      grant_d;
  logic [SW-1:0]        grant_slot_q, grant_slot_d;
  logic [NUM_SLOTS-1:0] launch_q,     launch_d;
  logic [NUM_SLOTS-1:0] slot_busy_q,  slot_busy_d;
  logic [CW-1:0]        busy_count_q, busy_count_d;
  logic [RW-1:0]        rr_ptr_q,     rr_ptr_d;
  logic [CDW-1:0]       cooldown_q [NUM_REQ];
  logic [CDW-1:0]       cooldown_d [NUM_REQ];

  // Selection
  logic [NUM_SLOTS-1:0] reserved_mask;
  logic [NUM_SLOTS-1:0] usable_any;
  logic [NUM_SLOTS-1:0] usable_shared;
  logic [NUM_SLOTS-1:0] slot_cand;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   win_oh;
  logic [RW-1:0]        win_idx;
  logic                 win_any;
  logic [NUM_SLOTS-1:0] slot_oh;
  logic [SW-1:0]        slot_idx;
  logic                 slot_any;
  logic                 do_grant;

  // Eligibility is computed on the registered occupancy only, so a slot
  // freed this cycle cannot be reallocated until the following cycle.
  always_comb begin
    reserved_mask = '0;
    for (int t = 0; t < NUM_SLOTS; t++) begin
      reserved_mask[t] = (t < RESERVED_SLOTS);
    end
    usable_any    = ~slot_busy_q;
    usable_shared = ~slot_busy_q & ~reserved_mask;
    eligible      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = fire_req[i] & req_enable[i] & enable &
                    (cooldown_q[i] == '0) &
                    ((i == REQ_PLAYER) ? (|usable_any) : (|usable_shared));
    end
  end

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (RW)
  ) u_req_picker (
    .req        (eligible),
    .ptr        (rr_ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .found      (win_any)
  );

  always_comb begin
    slot_cand = (int'(win_idx) == REQ_PLAYER) ? usable_any : usable_shared;
  end

  // Lowest-index usable slot for the winner.
  rr_priority_picker #(
    .N     (NUM_SLOTS),
    .IDX_W (SW)
  ) u_slot_picker (
    .req        (slot_cand),
    .ptr        ('0),
    .winner_oh  (slot_oh),
    .winner_idx (slot_idx),
    .found      (slot_any)
  );

  // A requester is only eligible when a usable slot exists, so slot_any is
  // always set alongside win_any; it is folded in as a guard.
  assign do_grant = win_any & slot_any;

  always_comb begin
    grant_d      = do_grant ? win_oh   : '0;
    launch_d     = do_grant ? slot_oh  : '0;
    grant_slot_d = do_grant ? slot_idx : '0;

    // Frees are applied before the new allocation is ORed in, so an
    // (illegal) free of the slot being allocated loses to the allocation.
    // Frees of idle slots are harmless: clearing a zero bit is a no-op.
    slot_busy_d = (slot_busy_q & ~slot_free) | launch_d;

    busy_count_d = '0;
    for (int t = 0; t < NUM_SLOTS; t++) begin
      busy_count_d = busy_count_d + CW'(slot_busy_d[t]);
    end

    rr_ptr_d = rr_ptr_q;
    if (do_grant) begin
      rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + RW'(1);
    end

    // Counters run regardless of req_enable; only the pause freezes them.
    for (int i = 0; i < NUM_REQ; i++) begin
      cooldown_d[i] = cooldown_q[i];
      if (enable && (cooldown_q[i] != '0)) begin
        cooldown_d[i] = cooldown_q[i] - CDW'(1);
      end
      if (do_grant && win_oh[i]) begin
        cooldown_d[i] = CDW'(COOLDOWN_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      grant_q      <= '0;
      grant_slot_q <= '0;
      launch_q     <= '0;
      slot_busy_q  <= '0;
      busy_count_q <= '0;
      rr_ptr_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cooldown_q[i] <= '0;
      end
    end else begin
      grant_q      <= grant_d;
      grant_slot_q <= grant_slot_d;
      launch_q     <= launch_d;
      slot_busy_q  <= slot_busy_d;
      busy_count_q <= busy_count_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cooldown_q[i] <= cooldown_d[i];
      end
    end
  end

  assign grant      = grant_q;
  assign grant_slot = grant_slot_q;
  assign launch     = launch_q;
  assign slot_busy  = slot_busy_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_missile_slot_arbiter.sv
// Bench for missile_slot_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the pool.
module tb_missile_slot_arbiter;

  localparam int NR    = 4;
  localparam int NS    = 8;
  localparam int RS    = 2;
  localparam int CD    = 16;
  localparam int EXP_W = NR + 3 + NS + NS + 4;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          enable;
  logic          clear;
  logic [NR-1:0] fire_req;
  logic [NR-1:0] req_enable;
  logic [NS-1:0] slot_free;
  logic [NR-1:0] grant;
  logic [2:0]    grant_slot;
  logic [NS-1:0] launch;
  logic [NS-1:0] slot_busy;
  logic [3:0]    busy_count;

  missile_slot_arbiter #(
    .NUM_REQ         (NR),
    .NUM_SLOTS       (NS),
    .RESERVED_SLOTS  (RS),
    .COOLDOWN_CYCLES (CD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .fire_req   (fire_req),
    .req_enable (req_enable),
    .slot_free  (slot_free),
    .grant      (grant),
    .grant_slot (grant_slot),
    .launch     (launch),
    .slot_busy  (slot_busy),
    .busy_count (busy_count)
  );

  // Scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model state: one flag per slot, one counter per requester.
  int m_busy[NS];
  int m_cd[NR];
  int m_rr;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies one clock edge to the model using the current inputs and
  // returns the outputs that should be visible after that edge.
  task automatic model_step(output logic [EXP_W-1:0] e);
    int w, s, r;
    logic [NR-1:0] g;
    logic [2:0]    gs;
    logic [NS-1:0] ln, bz;
    logic [3:0]    cnt;
    g = '0; gs = '0; ln = '0; bz = '0; cnt = '0;
    w = -1; s = -1;
    if (reset || clear) begin
      for (int t = 0; t < NS; t++) m_busy[t] = 0;
      for (int i = 0; i < NR; i++) m_cd[i] = 0;
      m_rr = 0;
    end else begin
      // Walk requesters in priority order; the first one that may fire and
      // has somewhere to put a missile wins.
      for (int k = 0; k < NR; k++) begin
        r = (m_rr + k) % NR;
        if (w < 0 && fire_req[r] && req_enable[r] && enable && m_cd[r] == 0) begin
          for (int t = (r == 0) ? 0 : RS; t < NS; t++) begin
            if (s < 0 && m_busy[t] == 0) s = t;
          end
          if (s >= 0) w = r;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (enable && m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
      end
      for (int t = 0; t < NS; t++) begin
        if (slot_free[t]) m_busy[t] = 0;
      end
      if (w >= 0) begin
        m_cd[w]   = CD;
        m_busy[s] = 1;
        m_rr      = (w + 1) % NR;
        g[w]      = 1'b1;
        gs        = 3'(s);
        ln[s]     = 1'b1;
      end
    end
    for (int t = 0; t < NS; t++) begin
      bz[t] = (m_busy[t] != 0);
      cnt   = cnt + 4'(m_busy[t] != 0);
    end
    e = {g, gs, ln, bz, cnt};
  endtask

  // Driver: one clock cycle with the currently applied inputs, followed by
  // a full comparison of the outputs against the model.
  task automatic tick();
    logic [EXP_W-1:0] e, x;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check_eq("grant",      32'(grant),      32'(x[26:23]));
    check_eq("grant_slot", 32'(grant_slot), 32'(x[22:20]));
    check_eq("launch",     32'(launch),     32'(x[19:12]));
    check_eq("slot_busy",  32'(slot_busy),  32'(x[11:4]));
    check_eq("busy_count", 32'(busy_count), 32'(x[3:0]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; enable = 1'b1;
    fire_req = '0; req_enable = '1; slot_free = '0;

    // Reset state
    tick();
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_launch", 32'(launch), 32'h0);
    check_eq("rst_busy", 32'(slot_busy), 32'h0);
    check_eq("rst_count", 32'(busy_count), 32'h0);
    reset = 1'b0;

    // Player alone: grant, then re-grant 17 cycles later
    fire_req = 4'b0001;
    tick();
    check_eq("t1_grant", 32'(grant), 32'h1);
    check_eq("t1_slot", 32'(grant_slot), 32'h0);
    check_eq("t1_launch", 32'(launch), 32'h01);
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq("t1_cooldown_nogrant", 32'(grant), 32'h0);
    end
    tick();
    check_eq("t1_regrant", 32'(grant), 32'h1);
    check_eq("t1_regrant_slot", 32'(grant_slot), 32'h1);
    check_eq("t1_busy", 32'(slot_busy), 32'h03);

    // Three non-player requesters from idle
    do_reset();
    fire_req = 4'b1110;
    tick();
    check_eq("t2_g1", 32'(grant), 32'h2);
    check_eq("t2_s1", 32'(grant_slot), 32'h2);
    tick();
    check_eq("t2_g2", 32'(grant), 32'h4);
    check_eq("t2_s2", 32'(grant_slot), 32'h3);
    tick();
    check_eq("t2_g3", 32'(grant), 32'h8);
    check_eq("t2_s3", 32'(grant_slot), 32'h4);

    // Fill the shared slots, then block requester 2 until a slot frees
    for (int k = 0; k < 17; k++) tick();
    check_eq("t3_shared_full", 32'(slot_busy), 32'hFC);
    fire_req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("t3_full_nogrant", 32'(grant), 32'h0);
    end
    check_eq("t3_count", 32'(busy_count), 32'd6);
    slot_free = 8'h20;
    tick();
    slot_free = '0;
    check_eq("t3_freed_nogrant", 32'(grant), 32'h0);
    tick();
    check_eq("t3_grant", 32'(grant), 32'h4);
    check_eq("t3_slot", 32'(grant_slot), 32'h5);

    // Clear with active cooldowns: pointer back to player, no wait
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("t5_busy", 32'(slot_busy), 32'h0);
    check_eq("t5_count", 32'(busy_count), 32'h0);
    fire_req = 4'b1111;
    tick();
    check_eq("t5_grant", 32'(grant), 32'h1);
    check_eq("t5_slot", 32'(grant_slot), 32'h0);
    tick();
    check_eq("t5_next", 32'(grant), 32'h2);
    check_eq("t5_next_slot", 32'(grant_slot), 32'h2);

    // Pause mid-cooldown with a free during the pause
    do_reset();
    fire_req = 4'b0001;
    tick();
    check_eq("t4_grant", 32'(grant), 32'h1);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      slot_free = (k == 4) ? 8'h01 : 8'h00;
      tick();
      check_eq("t4_pause_nogrant", 32'(grant), 32'h0);
    end
    slot_free = '0;
    check_eq("t4_pause_freed", 32'(slot_busy), 32'h0);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq("t4_resume_nogrant", 32'(grant), 32'h0);
    end
    tick();
    check_eq("t4_resume_grant", 32'(grant), 32'h1);
    check_eq("t4_resume_slot", 32'(grant_slot), 32'h0);

    // Masked requester never wins until unmasked
    do_reset();
    fire_req   = 4'b0100;
    req_enable = 4'b1011;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("t6_masked", 32'(grant), 32'h0);
    end
    req_enable = 4'b1111;
    tick();
    check_eq("t6_grant", 32'(grant), 32'h4);
    check_eq("t6_slot", 32'(grant_slot), 32'h2);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      fire_req   = 4'($urandom_range(0, 15));
      req_enable = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      enable     = ($urandom_range(0, 9) != 0);
      for (int t = 0; t < NS; t++) slot_free[t] = ($urandom_range(0, 5) == 0);
      clear      = ($urandom_range(0, 199) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; clear = 1'b0; slot_free = '0; fire_req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
